// File: rtl/pipefft_twid_fetch_if.sv
// Handshake and twiddle-RAM read-port bundle for pipefft_twid_fetch.
// master: frame controller plus RAM read-data source; slave: the fetch stage.
interface pipefft_twid_fetch_if #(
   parameter int unsigned LOGN   = 11,
   parameter int unsigned TWID_W = 32
) ();
   logic                  START;
   logic                  INVERSE;
   logic                  DATA_VALID;
   logic [LOGN-2:0]       RADDR;
   logic                  RDB;
   logic [2*TWID_W-1:0]   DO;
   logic [TWID_W-1:0]     TW_RE;
   logic [TWID_W-1:0]     TW_IM;
   logic                  TW_VALID;
   logic                  BUSY;
   logic                  FRAME_DONE;

   modport master (
      output START, INVERSE, DATA_VALID, DO,
      input  RADDR, RDB, TW_RE, TW_IM, TW_VALID, BUSY, FRAME_DONE
   );

   modport slave (
      input  START, INVERSE, DATA_VALID, DO,
      output RADDR, RDB, TW_RE, TW_IM, TW_VALID, BUSY, FRAME_DONE
   );
endinterface

// File: rtl/pipefft_twid_fetch.sv
// Twiddle fetch for one radix-2 DIF stage: RAM address generation, unity bypass for the
// upper butterfly leg, optional conjugation, all on a fixed-latency pipeline. RAM_LAT >= 1.
module pipefft_twid_fetch #(
   parameter int unsigned LOGN    = 11,
   parameter int unsigned STAGE   = 0,
   parameter int unsigned TWID_W  = 32,
   parameter int unsigned RAM_LAT = 2
) (
   input logic                  CLK,
   input logic                  RST,
   pipefft_twid_fetch_if.slave  bus
);

   localparam int unsigned AddrW   = LOGN - 1;
   localparam int unsigned HalfBit = LOGN - STAGE - 1;
   localparam logic [LOGN-1:0]   OffMask = LOGN'((1 << HalfBit) - 1);
   localparam logic [TWID_W-1:0] TwMax   = {1'b0, {(TWID_W-1){1'b1}}};
   localparam logic [TWID_W-1:0] TwMin   = {1'b1, {(TWID_W-1){1'b0}}};

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q, state_d;
   logic [LOGN-1:0]   cnt_q, cnt_d;
   logic              inv_q, inv_d;
   logic              done_q;
   logic              accept, last_accept;

   assign accept      = (state_q == StRun) & bus.DATA_VALID;
   assign last_accept = accept & (&cnt_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      unique case (state_q)
         StIdle: begin
            if (bus.START) begin
               state_d = StRun;
               cnt_d   = '0;
               inv_d   = bus.INVERSE;
            end
         end
         StRun: begin
            if (last_accept) begin
               // A START coinciding with the final sample chains straight into the next frame
               cnt_d = '0;
               if (bus.START) begin
                  inv_d = bus.INVERSE;
               end else begin
                  state_d = StIdle;
               end
            end else if (accept) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
         done_q  <= last_accept;
      end
   end

   // Within a block of M = N >> STAGE samples, the MSB of pos selects the rotated lower leg
   logic              lower_leg;
   logic [LOGN-1:0]   addr_full;
   logic              rdb_q;
   logic [AddrW-1:0]  raddr_q;

   assign lower_leg = cnt_q[HalfBit];
   assign addr_full = (cnt_q & OffMask) << STAGE;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rdb_q   <= 1'b0;
         raddr_q <= '0;
      end else begin
         rdb_q <= accept & lower_leg;
         if (accept & lower_leg) begin
            raddr_q <= addr_full[AddrW-1:0];
         end
      end
   end

   // Side-band delay line matching the RAM: index 0 aligns with RADDR, index RAM_LAT with DO
   logic [RAM_LAT:0]  vld_pipe, byp_pipe, inv_pipe;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         vld_pipe <= '0;
         byp_pipe <= '0;
         inv_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[RAM_LAT-1:0], accept};
         byp_pipe <= {byp_pipe[RAM_LAT-1:0], ~lower_leg};
         inv_pipe <= {inv_pipe[RAM_LAT-1:0], inv_q};
      end
   end

   logic [TWID_W-1:0] do_re, do_im, im_neg;
   logic [TWID_W-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;
   logic              tw_valid_q;

   assign do_re  = bus.DO[TWID_W-1:0];
   assign do_im  = bus.DO[2*TWID_W-1:TWID_W];
   assign im_neg = (do_im == TwMin) ? TwMax : -do_im;

   always_comb begin
      tw_re_d = tw_re_q;
      tw_im_d = tw_im_q;
      if (vld_pipe[RAM_LAT]) begin
         if (byp_pipe[RAM_LAT]) begin
            tw_re_d = TwMax;
            tw_im_d = '0;
         end else begin
            tw_re_d = do_re;
            tw_im_d = inv_pipe[RAM_LAT] ? im_neg : do_im;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tw_re_q    <= '0;
         tw_im_q    <= '0;
         tw_valid_q <= 1'b0;
      end else begin
         tw_re_q    <= tw_re_d;
         tw_im_q    <= tw_im_d;
         tw_valid_q <= vld_pipe[RAM_LAT];
      end
   end

   assign bus.RADDR      = raddr_q;
   assign bus.RDB        = rdb_q;
   assign bus.TW_RE      = tw_re_q;
   assign bus.TW_IM      = tw_im_q;
   assign bus.TW_VALID   = tw_valid_q;
   assign bus.BUSY       = (state_q == StRun);
   assign bus.FRAME_DONE = done_q;

endmodule

// File: tb/tb_pipefft_twid_fetch.sv
// Scoreboard bench: STAGE=0 and STAGE=3 instances share one stimulus stream, each with its
// own two-cycle RAM model; expected twiddles are queued at issue and popped on TW_VALID.
module tb_pipefft_twid_fetch;

   logic clk;
   logic rst;
   logic start, inverse, data_valid;
   int unsigned cyc;
   int unsigned checks;
   int unsigned errors;

   typedef struct {
      logic [63:0] val;
      int unsigned cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q3[$];

   // Bench-side frame model
   logic m_busy, m_inv;
   int   m_cnt;
   logic e_done, e_rdb0, e_rdb3;
   logic [9:0] e_addr0, e_addr3;

   pipefft_twid_fetch_if #(.LOGN(11), .TWID_W(32)) if0 ();
   pipefft_twid_fetch_if #(.LOGN(11), .TWID_W(32)) if3 ();

   pipefft_twid_fetch #(.LOGN(11), .STAGE(0), .TWID_W(32), .RAM_LAT(2)) dut0 (
      .CLK (clk),
      .RST (rst),
      .bus (if0.slave)
   );

   pipefft_twid_fetch #(.LOGN(11), .STAGE(3), .TWID_W(32), .RAM_LAT(2)) dut3 (
      .CLK (clk),
      .RST (rst),
      .bus (if3.slave)
   );

   assign if0.START      = start;
   assign if0.INVERSE    = inverse;
   assign if0.DATA_VALID = data_valid;
   assign if3.START      = start;
   assign if3.INVERSE    = inverse;
   assign if3.DATA_VALID = data_valid;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] mem_val(input int j);
      if (j == 5) return {32'h0000_1234, 32'h3000_0005};
      if (j == 6) return {32'h8000_0000, 32'h3000_0006};
      return {32'(32'h2000_0000 + j * 3), 32'(32'h1000_0000 + j)};
   endfunction

   function automatic logic [63:0] exp_tw(input int stage, input int cnt, input logic inv);
      int m, pos, j;
      logic [63:0] w;
      logic [31:0] im;
      m   = 2048 >> stage;
      pos = cnt % m;
      if (pos < m / 2) return {32'h0000_0000, 32'h7FFF_FFFF};
      j  = (pos - m / 2) << stage;
      w  = mem_val(j);
      im = w[63:32];
      if (inv) begin
         if (j == 5)      im = 32'hFFFF_EDCC;
         else if (j == 6) im = 32'h7FFF_FFFF;
         else             im = -im;
      end
      return {im, w[31:0]};
   endfunction

   function automatic logic [10:0] read_req(input int stage, input int cnt);
      int m, pos;
      m   = 2048 >> stage;
      pos = cnt % m;
      if (pos < m / 2) return 11'h0;
      return {1'b1, 10'((pos - m / 2) << stage)};
   endfunction

   // Two-stage read pipeline: address captured, then output register
   logic [63:0] mem [1024];
   logic [63:0] rd0, do0, rd3, do3;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = mem_val(i);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd0 <= '0; do0 <= '0; rd3 <= '0; do3 <= '0;
      end else begin
         if (if0.RDB) rd0 <= mem[if0.RADDR];
         if (if3.RDB) rd3 <= mem[if3.RADDR];
         do0 <= rd0;
         do3 <= rd3;
      end
   end

   assign if0.DO = do0;
   assign if3.DO = do3;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_idle();
      chk("rst_raddr0", 64'(if0.RADDR), 64'h0);
      chk("rst_rdb0", 64'(if0.RDB), 64'h0);
      chk("rst_tw0", {if0.TW_IM, if0.TW_RE}, 64'h0);
      chk("rst_ctl0", {if0.TW_VALID, if0.BUSY, if0.FRAME_DONE}, 64'h0);
      chk("rst_raddr3", 64'(if3.RADDR), 64'h0);
      chk("rst_rdb3", 64'(if3.RDB), 64'h0);
      chk("rst_tw3", {if3.TW_IM, if3.TW_RE}, 64'h0);
      chk("rst_ctl3", {if3.TW_VALID, if3.BUSY, if3.FRAME_DONE}, 64'h0);
   endtask

   task automatic model_clear();
      q0.delete();
      q3.delete();
      m_busy = 1'b0; m_inv = 1'b0; m_cnt = 0;
      e_done = 1'b0; e_rdb0 = 1'b0; e_rdb3 = 1'b0;
      e_addr0 = '0; e_addr3 = '0;
   endtask

   // Checks registered outputs caused by the previous step, then issues this cycle's inputs
   task automatic step(input logic s, input logic inv, input logic dv);
      logic acc, last;
      logic [10:0] r0, r3;
      chk("busy0", 64'(if0.BUSY), 64'(m_busy));
      chk("busy3", 64'(if3.BUSY), 64'(m_busy));
      chk("done0", 64'(if0.FRAME_DONE), 64'(e_done));
      chk("done3", 64'(if3.FRAME_DONE), 64'(e_done));
      chk("rdb0", 64'(if0.RDB), 64'(e_rdb0));
      chk("rdb3", 64'(if3.RDB), 64'(e_rdb3));
      if (e_rdb0) chk("raddr0", 64'(if0.RADDR), 64'(e_addr0));
      if (e_rdb3) chk("raddr3", 64'(if3.RADDR), 64'(e_addr3));

      start = s; inverse = inv; data_valid = dv;
      acc  = m_busy && dv;
      last = acc && (m_cnt == 2047);
      r0   = acc ? read_req(0, m_cnt) : 11'h0;
      r3   = acc ? read_req(3, m_cnt) : 11'h0;
      e_done  = last;
      e_rdb0  = r0[10];
      e_rdb3  = r3[10];
      e_addr0 = r0[9:0];
      e_addr3 = r3[9:0];
      if (acc) begin
         q0.push_back('{val: exp_tw(0, m_cnt, m_inv), cyc: cyc});
         q3.push_back('{val: exp_tw(3, m_cnt, m_inv), cyc: cyc});
      end

      if (!m_busy) begin
         if (s) begin m_busy = 1'b1; m_cnt = 0; m_inv = inv; end
      end else if (last) begin
         m_cnt = 0;
         if (s) m_inv = inv;
         else   m_busy = 1'b0;
      end else if (acc) begin
         m_cnt++;
      end
      @(posedge clk); #2;
   endtask

   task automatic do_reset(input int hold);
      rst = 1'b1;
      start = 1'b0; inverse = 1'b0; data_valid = 1'b0;
      model_clear();
      repeat (hold) begin
         @(posedge clk); #2;
         chk_idle();
      end
      rst = 1'b0;
   endtask

   logic [63:0] last0, last3;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last0 = '0;
      end else if (if0.TW_VALID) begin
         if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL tw0_unexpected: got TW_VALID with %h, expected none", {if0.TW_IM, if0.TW_RE});
         end else begin
            e = q0.pop_front();
            chk("tw0", {if0.TW_IM, if0.TW_RE}, e.val);
            chk("lat0", 64'(cyc), 64'(e.cyc + 4));
            last0 = e.val;
         end
      end else begin
         chk("hold0", {if0.TW_IM, if0.TW_RE}, last0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last3 = '0;
      end else if (if3.TW_VALID) begin
         if (q3.size() == 0) begin
            checks++; errors++;
            $display("FAIL tw3_unexpected: got TW_VALID with %h, expected none", {if3.TW_IM, if3.TW_RE});
         end else begin
            e = q3.pop_front();
            chk("tw3", {if3.TW_IM, if3.TW_RE}, e.val);
            chk("lat3", 64'(cyc), 64'(e.cyc + 4));
            last3 = e.val;
         end
      end else begin
         chk("hold3", {if3.TW_IM, if3.TW_RE}, last3);
      end
   end

   initial begin
      int  done_b;
      logic dv, s;
      checks = 0; errors = 0; cyc = 0;
      rst = 1'b1;
      start = 1'b0; inverse = 1'b0; data_valid = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #2;

      // Reset held with random inputs
      for (int i = 0; i < 5; i++) begin
         start      = 1'($urandom_range(0, 1));
         inverse    = 1'($urandom_range(0, 1));
         data_valid = 1'($urandom_range(0, 1));
         @(posedge clk); #2;
         chk_idle();
      end
      start = 1'b0; inverse = 1'b0; data_valid = 1'b0;
      rst = 1'b0;

      // DATA_VALID without START is ignored
      repeat (6) step(1'b0, 1'b0, 1'b1);

      // Forward frame, continuous, with a mid-frame START that must be ignored
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2048; i++) step(i == 500, 1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0, 1'b0);

      // Inverse frame with random gaps; START on the last accept chains a forward frame
      step(1'b1, 1'b1, 1'b0);
      done_b = 0;
      while (done_b == 0) begin
         dv = ($urandom_range(0, 3) != 0);
         s  = dv && (m_cnt == 2047);
         step(s, 1'b0, dv);
         if (s) done_b = 1;
      end

      // Chained frame runs to cnt=700, then reset with reads in flight
      for (int i = 0; i < 700; i++) step(1'b0, 1'b0, 1'b1);
      do_reset(2);
      repeat (8) step(1'b0, 1'b0, 1'b0);

      // Restart after reset must begin at cnt=0
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 1100; i++) step(1'b0, 1'b0, 1'b1);
      repeat (8) step(1'b0, 1'b0, 1'b0);

      chk("q0_drained", 64'(q0.size()), 64'h0);
      chk("q3_drained", 64'(q3.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
